// File: rtl/simd_wb_pkg.sv
// Shared definitions for the SIMD register-file writeback path: geometry
// constants, forwarding select codes, the pipeline entry record and the
// priority rule that turns per-pipe address hits into a bypass select.
package simd_wb_pkg;

  localparam int WB_WIDTH = 128;
  localparam int WB_ADDRW = 7;
  localparam int WB_DEPTH = 7;
  localparam int WB_LATW  = 3;

  localparam logic [4:0] FWD_NONE = 5'b00000;
  localparam logic [4:0] FWD_E    = 5'b01010;
  localparam logic [4:0] FWD_O    = 5'b11000;

  typedef struct packed {
    logic                valid;
    logic [WB_ADDRW-1:0] rt;
    logic [WB_WIDTH-1:0] data;
  } wb_entry_t;

  // Odd pipe has priority: it is the one that actually writes when both
  // pipes retire the same register.
  function automatic logic [4:0] fwd_select(input logic hit_e, input logic hit_o);
    logic [4:0] sel;
    if (hit_o) begin
      sel = FWD_O;
    end else if (hit_e) begin
      sel = FWD_E;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/result_shift_pipe.sv
// DEPTH-stage result delay line for one issue pipe. A result of latency L
// enters at stage DEPTH-L+1 and shifts one stage per cycle until it reaches
// stage DEPTH, which is presented as the retiring head entry.
//
// Insertion handshake: ins_v is a single-cycle strobe with no back-pressure;
// a strobed result is either accepted into its slot at that edge or dropped,
// and drop reports the drop combinationally in the same cycle.
module result_shift_pipe
  import simd_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int LATW  = WB_LATW
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                flush,
  input  logic                ins_v,
  input  logic [WB_ADDRW-1:0] ins_rt,
  input  logic [LATW-1:0]     ins_lat,
  input  logic [WB_WIDTH-1:0] ins_data,
  output wb_entry_t           head,
  output logic                drop
);

  wb_entry_t stage_q [1:DEPTH];
  wb_entry_t stage_d [1:DEPTH];
  int        lat_i;
  logic      lat_ok;
  logic      conflict;
  logic      accept;

  // Decide whether the new result can take its slot. The slot it lands in
  // is filled at this edge by whatever sits one stage earlier, so an older
  // valid entry there wins and the new result is dropped.
  always_comb begin
    lat_i    = int'(ins_lat);
    lat_ok   = (lat_i >= 1) && (lat_i <= DEPTH);
    conflict = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if ((lat_i == DEPTH - k) && stage_q[k].valid) begin
        conflict = 1'b1;
      end
    end
    accept = ins_v && !flush && lat_ok && !conflict;
    drop   = ins_v && !flush && !accept;
  end

  // Next stage contents: shift by one, then either flush every valid bit or
  // drop the accepted result into stage DEPTH-L+1.
  always_comb begin
    stage_d[1] = '0;
    for (int k = 2; k <= DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (flush) begin
        stage_d[k].valid = 1'b0;
      end else if (accept && (k == DEPTH - lat_i + 1)) begin
        stage_d[k] = {1'b1, ins_rt, ins_data};
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign head = stage_q[DEPTH];

endmodule

// File: rtl/result_writeback_unit.sv
// Writer side of the SIMD register file. Each issue pipe's results are
// delayed by their unit latency in a result_shift_pipe; the retiring heads
// are registered onto the WB*/Address*/Data* write ports. In the same cycle
// the six read addresses are compared with the retiring heads so operand
// reads bypass registers written that cycle.
//
// Handshake: EvenV/OddV are single-cycle valid strobes with no ready; the
// unit never stalls the execution pipes and reports a rejected result with a
// one-cycle ErrE/ErrO pulse instead.
module result_writeback_unit
  import simd_wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int ADDRW = WB_ADDRW,
  parameter int DEPTH = WB_DEPTH,
  parameter int LATW  = WB_LATW
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             Flush,
  input  logic             EvenV,
  input  logic [ADDRW-1:0] EvenRT,
  input  logic [LATW-1:0]  EvenLat,
  input  logic [WIDTH-1:0] EvenRes,
  input  logic             OddV,
  input  logic [ADDRW-1:0] OddRT,
  input  logic [LATW-1:0]  OddLat,
  input  logic [WIDTH-1:0] OddRes,
  input  logic [ADDRW-1:0] RAE,
  input  logic [ADDRW-1:0] RBE,
  input  logic [ADDRW-1:0] RCE,
  input  logic [ADDRW-1:0] RAO,
  input  logic [ADDRW-1:0] RBO,
  input  logic [ADDRW-1:0] RCO,
  output logic             WBE,
  output logic             WBO,
  output logic [ADDRW-1:0] AddressEi,
  output logic [ADDRW-1:0] AddressOi,
  output logic [WIDTH-1:0] DataE,
  output logic [WIDTH-1:0] DataO,
  output logic [4:0]       ForwardE1,
  output logic [4:0]       ForwardE2,
  output logic [4:0]       ForwardE3,
  output logic [4:0]       ForwardO1,
  output logic [4:0]       ForwardO2,
  output logic [4:0]       ForwardO3,
  output logic             ErrE,
  output logic             ErrO
);

  // The entry record fixes the register-file geometry; WIDTH/ADDRW are
  // expected to match WB_WIDTH/WB_ADDRW.
  wb_entry_t        even_head;
  wb_entry_t        odd_head;
  logic             even_drop;
  logic             odd_drop;
  logic             collide;
  logic             we_d;
  logic             wo_d;
  logic [ADDRW-1:0] rd_addr [6];
  logic [4:0]       fwd_d   [6];
  logic [4:0]       fwd_q   [6];

  result_shift_pipe #(.DEPTH(DEPTH), .LATW(LATW)) u_even_pipe (
    .clk      (clk),
    .nReset   (nReset),
    .flush    (Flush),
    .ins_v    (EvenV),
    .ins_rt   (EvenRT),
    .ins_lat  (EvenLat),
    .ins_data (EvenRes),
    .head     (even_head),
    .drop     (even_drop)
  );

  result_shift_pipe #(.DEPTH(DEPTH), .LATW(LATW)) u_odd_pipe (
    .clk      (clk),
    .nReset   (nReset),
    .flush    (Flush),
    .ins_v    (OddV),
    .ins_rt   (OddRT),
    .ins_lat  (OddLat),
    .ins_data (OddRes),
    .head     (odd_head),
    .drop     (odd_drop)
  );

  // Both pipes retiring the same register: only the odd write goes out.
  always_comb begin
    collide = even_head.valid && odd_head.valid && (even_head.rt == odd_head.rt);
    we_d    = even_head.valid && !collide;
    wo_d    = odd_head.valid;
  end

  // Six bypass comparators against the heads retiring at this edge.
  always_comb begin
    rd_addr[0] = RAE;
    rd_addr[1] = RBE;
    rd_addr[2] = RCE;
    rd_addr[3] = RAO;
    rd_addr[4] = RBO;
    rd_addr[5] = RCO;
    for (int i = 0; i < 6; i++) begin
      fwd_d[i] = fwd_select(even_head.valid && (even_head.rt == rd_addr[i]),
                            odd_head.valid  && (odd_head.rt  == rd_addr[i]));
    end
  end

  // Write-port, error and forward registers. Flush does not touch these, so
  // an entry retiring at the flush edge still writes and keeps its forwards.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      WBE       <= 1'b0;
      WBO       <= 1'b0;
      AddressEi <= '0;
      AddressOi <= '0;
      DataE     <= '0;
      DataO     <= '0;
      ErrE      <= 1'b0;
      ErrO      <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        fwd_q[i] <= FWD_NONE;
      end
    end else begin
      WBE  <= we_d;
      WBO  <= wo_d;
      ErrE <= even_drop;
      ErrO <= odd_drop;
      if (we_d) begin
        AddressEi <= even_head.rt;
        DataE     <= even_head.data;
      end
      if (wo_d) begin
        AddressOi <= odd_head.rt;
        DataO     <= odd_head.data;
      end
      for (int i = 0; i < 6; i++) begin
        fwd_q[i] <= fwd_d[i];
      end
    end
  end

  assign ForwardE1 = fwd_q[0];
  assign ForwardE2 = fwd_q[1];
  assign ForwardE3 = fwd_q[2];
  assign ForwardO1 = fwd_q[3];
  assign ForwardO2 = fwd_q[4];
  assign ForwardO3 = fwd_q[5];

endmodule

// File: tb/tb_result_writeback_unit.sv
// Directed bench for result_writeback_unit. Each table row is one cycle of
// stimulus plus the outputs expected right after that cycle's rising edge.
module tb_result_writeback_unit;
  import simd_wb_pkg::*;

  localparam logic [6:0] IDLE_RD = 7'd127;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  logic         Flush = 1'b0;
  logic         EvenV = 1'b0;
  logic [6:0]   EvenRT = '0;
  logic [2:0]   EvenLat = '0;
  logic [127:0] EvenRes = '0;
  logic         OddV = 1'b0;
  logic [6:0]   OddRT = '0;
  logic [2:0]   OddLat = '0;
  logic [127:0] OddRes = '0;
  logic [6:0]   RAE = IDLE_RD, RBE = IDLE_RD, RCE = IDLE_RD;
  logic [6:0]   RAO = IDLE_RD, RBO = IDLE_RD, RCO = IDLE_RD;
  logic         WBE, WBO, ErrE, ErrO;
  logic [6:0]   AddressEi, AddressOi;
  logic [127:0] DataE, DataO;
  logic [4:0]   ForwardE1, ForwardE2, ForwardE3, ForwardO1, ForwardO2, ForwardO3;

  always #5 clk = ~clk;

  result_writeback_unit dut (
    .clk(clk), .nReset(nReset), .Flush(Flush),
    .EvenV(EvenV), .EvenRT(EvenRT), .EvenLat(EvenLat), .EvenRes(EvenRes),
    .OddV(OddV), .OddRT(OddRT), .OddLat(OddLat), .OddRes(OddRes),
    .RAE(RAE), .RBE(RBE), .RCE(RCE), .RAO(RAO), .RBO(RBO), .RCO(RCO),
    .WBE(WBE), .WBO(WBO), .AddressEi(AddressEi), .AddressOi(AddressOi),
    .DataE(DataE), .DataO(DataO),
    .ForwardE1(ForwardE1), .ForwardE2(ForwardE2), .ForwardE3(ForwardE3),
    .ForwardO1(ForwardO1), .ForwardO2(ForwardO2), .ForwardO3(ForwardO3),
    .ErrE(ErrE), .ErrO(ErrO)
  );

  // ---------------- vector table ----------------
  typedef struct {
    string          name;
    logic           flush;
    logic           ev;
    logic [6:0]     ert;
    logic [2:0]     elat;
    logic [7:0]     eb;
    logic           ov;
    logic [6:0]     ort;
    logic [2:0]     olat;
    logic [7:0]     ob;
    logic [5:0][6:0] rd;
    logic           x_wbe;
    logic [6:0]     x_ae;
    logic [7:0]     x_de;
    logic           x_wbo;
    logic [6:0]     x_ao;
    logic [7:0]     x_do;
    logic           x_erre;
    logic           x_erro;
    logic [5:0][4:0] x_fwd;
  } vec_t;

  vec_t vecs[$];
  logic [5:0][6:0] pend_rd  = {6{IDLE_RD}};
  logic [5:0][4:0] pend_fwd = '0;

  int applied     = 0;
  int miscompares = 0;

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  // Read address (index 0..5 = RAE,RBE,RCE,RAO,RBO,RCO) for the next row
  // built, with the forward select expected for it.
  task automatic fwd(input int idx, input logic [6:0] a, input logic [4:0] code);
    pend_rd[idx]  = a;
    pend_fwd[idx] = code;
  endtask

  function automatic vec_t mk(
    input string nm, input logic fl,
    input logic ev, input logic [6:0] ert, input logic [2:0] elat, input logic [7:0] eb,
    input logic ov, input logic [6:0] ort, input logic [2:0] olat, input logic [7:0] ob,
    input logic xwbe, input logic [6:0] xae, input logic [7:0] xde,
    input logic xwbo, input logic [6:0] xao, input logic [7:0] xdo,
    input logic xerre, input logic xerro);
    vec_t v;
    v.name = nm; v.flush = fl;
    v.ev = ev; v.ert = ert; v.elat = elat; v.eb = eb;
    v.ov = ov; v.ort = ort; v.olat = olat; v.ob = ob;
    v.rd = pend_rd; v.x_fwd = pend_fwd;
    v.x_wbe = xwbe; v.x_ae = xae; v.x_de = xde;
    v.x_wbo = xwbo; v.x_ao = xao; v.x_do = xdo;
    v.x_erre = xerre; v.x_erro = xerro;
    pend_rd  = {6{IDLE_RD}};
    pend_fwd = '0;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string vn, input string fld, input logic [127:0] act,
                     input logic [127:0] exp, inout bit bad);
    if (act !== exp) begin
      $display("FAIL %s %s: got %0h want %0h", vn, fld, act, exp);
      bad = 1'b1;
    end
  endtask

  task automatic check_vec(input vec_t v);
    bit bad;
    logic [5:0][4:0] act_f;
    bad = 1'b0;
    act_f = {ForwardO3, ForwardO2, ForwardO1, ForwardE3, ForwardE2, ForwardE1};
    chk(v.name, "WBE", WBE, v.x_wbe, bad);
    chk(v.name, "AddressEi", AddressEi, v.x_ae, bad);
    chk(v.name, "DataE", DataE, fill(v.x_de), bad);
    chk(v.name, "WBO", WBO, v.x_wbo, bad);
    chk(v.name, "AddressOi", AddressOi, v.x_ao, bad);
    chk(v.name, "DataO", DataO, fill(v.x_do), bad);
    chk(v.name, "ErrE", ErrE, v.x_erre, bad);
    chk(v.name, "ErrO", ErrO, v.x_erro, bad);
    for (int i = 0; i < 6; i++) begin
      chk(v.name, $sformatf("fwd%0d", i), act_f[i], v.x_fwd[i], bad);
    end
    applied++;
    if (bad) miscompares++;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    Flush = v.flush;
    EvenV = v.ev; EvenRT = v.ert; EvenLat = v.elat; EvenRes = fill(v.eb);
    OddV = v.ov; OddRT = v.ort; OddLat = v.olat; OddRes = fill(v.ob);
    RAE = v.rd[0]; RBE = v.rd[1]; RCE = v.rd[2];
    RAO = v.rd[3]; RBO = v.rd[4]; RCO = v.rd[5];
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_vec(v);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_vec(mk("reset", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0));
    @(negedge clk);
    nReset = 1'b1;

    // Even Lat=2 to RT5.
    vecs.push_back(mk("a_ins",  0, 1,5,2,8'hA5, 0,0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0));
    vecs.push_back(mk("a_wait", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0));
    vecs.push_back(mk("a_ret",  0, 0,0,0,8'h00, 0,0,0,8'h00, 1,5,8'hA5, 0,0,8'h00, 0,0));
    vecs.push_back(mk("a_hold", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,5,8'hA5, 0,0,8'h00, 0,0));
    // Odd Lat=3 to RT9, read RAE=9 when it retires.
    vecs.push_back(mk("b_ins",  0, 0,0,0,8'h00, 1,9,3,8'h3C, 0,5,8'hA5, 0,0,8'h00, 0,0));
    vecs.push_back(mk("b_w1",   0, 0,0,0,8'h00, 0,0,0,8'h00, 0,5,8'hA5, 0,0,8'h00, 0,0));
    vecs.push_back(mk("b_w2",   0, 0,0,0,8'h00, 0,0,0,8'h00, 0,5,8'hA5, 0,0,8'h00, 0,0));
    fwd(0, 9, FWD_O);
    vecs.push_back(mk("b_fwd",  0, 0,0,0,8'h00, 0,0,0,8'h00, 0,5,8'hA5, 1,9,8'h3C, 0,0));
    vecs.push_back(mk("b_hold", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,5,8'hA5, 0,9,8'h3C, 0,0));
    // Same register retiring on both pipes: odd wins.
    vecs.push_back(mk("c_e",    0, 1,12,2,8'h11, 0,0,0,8'h00, 0,5,8'hA5, 0,9,8'h3C, 0,0));
    vecs.push_back(mk("c_o",    0, 0,0,0,8'h00, 1,12,1,8'h22, 0,5,8'hA5, 0,9,8'h3C, 0,0));
    fwd(0, 12, FWD_O); fwd(4, 12, FWD_O); fwd(2, 5, FWD_NONE);
    vecs.push_back(mk("c_col",  0, 0,0,0,8'h00, 0,0,0,8'h00, 0,5,8'hA5, 1,12,8'h22, 0,0));
    // Distinct registers on both pipes, mixed forwards.
    vecs.push_back(mk("d_ins",  0, 1,20,1,8'h33, 1,21,1,8'h44, 0,5,8'hA5, 0,12,8'h22, 0,0));
    fwd(0, 20, FWD_E); fwd(1, 21, FWD_O); fwd(2, 22, FWD_NONE);
    fwd(3, 21, FWD_O); fwd(4, 20, FWD_E); fwd(5, 20, FWD_E);
    vecs.push_back(mk("d_ret",  0, 0,0,0,8'h00, 0,0,0,8'h00, 1,20,8'h33, 1,21,8'h44, 0,0));
    // Slot conflict: Lat=3 then Lat=2 one cycle later.
    vecs.push_back(mk("e_ins1", 0, 1,30,3,8'h55, 0,0,0,8'h00, 0,20,8'h33, 0,21,8'h44, 0,0));
    vecs.push_back(mk("e_ins2", 0, 1,31,2,8'h66, 0,0,0,8'h00, 0,20,8'h33, 0,21,8'h44, 1,0));
    vecs.push_back(mk("e_err0", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,20,8'h33, 0,21,8'h44, 0,0));
    vecs.push_back(mk("e_ret",  0, 0,0,0,8'h00, 0,0,0,8'h00, 1,30,8'h55, 0,21,8'h44, 0,0));
    vecs.push_back(mk("e_hold", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,30,8'h55, 0,21,8'h44, 0,0));
    // Lat=0 on odd is dropped; Lat=1 on even is the shortest path.
    vecs.push_back(mk("f_lat0", 0, 1,41,1,8'h88, 1,40,0,8'h77, 0,30,8'h55, 0,21,8'h44, 0,1));
    vecs.push_back(mk("f_lat1", 0, 0,0,0,8'h00, 0,0,0,8'h00, 1,41,8'h88, 0,21,8'h44, 0,0));
    // Lat=DEPTH on both pipes.
    vecs.push_back(mk("g_lat7", 0, 1,43,7,8'hAA, 1,42,7,8'h99, 0,41,8'h88, 0,21,8'h44, 0,0));
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk("g_wait", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,41,8'h88, 0,21,8'h44, 0,0));
    end
    vecs.push_back(mk("g_ret",  0, 0,0,0,8'h00, 0,0,0,8'h00, 1,43,8'hAA, 1,42,8'h99, 0,0));
    // Flush two cycles after a Lat=4 insert; odd entry retires at the flush edge.
    vecs.push_back(mk("h_lat4", 0, 1,50,4,8'hB1, 0,0,0,8'h00, 0,43,8'hAA, 0,42,8'h99, 0,0));
    vecs.push_back(mk("h_o1",   0, 0,0,0,8'h00, 1,52,1,8'hB3, 0,43,8'hAA, 0,42,8'h99, 0,0));
    fwd(3, 52, FWD_O);
    vecs.push_back(mk("h_flush",1, 1,53,1,8'hB4, 0,0,0,8'h00, 0,43,8'hAA, 1,52,8'hB3, 0,0));
    vecs.push_back(mk("h_post1",0, 0,0,0,8'h00, 0,0,0,8'h00, 0,43,8'hAA, 0,52,8'hB3, 0,0));
    vecs.push_back(mk("h_post2",0, 0,0,0,8'h00, 0,0,0,8'h00, 0,43,8'hAA, 0,52,8'hB3, 0,0));
    vecs.push_back(mk("h_post3",0, 0,0,0,8'h00, 0,0,0,8'h00, 0,43,8'hAA, 0,52,8'hB3, 0,0));

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset with three entries in flight.
    apply(mk("r_ins1", 0, 1,60,1,8'hC1, 1,61,2,8'hC2, 0,43,8'hAA, 0,52,8'hB3, 0,0));
    apply(mk("r_ins2", 0, 1,62,3,8'hC3, 1,63,4,8'hC4, 1,60,8'hC1, 0,52,8'hB3, 0,0));
    apply(mk("r_ins3", 0, 1,64,5,8'hC5, 0,0,0,8'h00, 0,60,8'hC1, 1,61,8'hC2, 0,0));
    @(negedge clk);
    v = mk("r_now", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0);
    drive(v);
    nReset = 1'b0;
    #1;
    check_vec(v);
    @(posedge clk);
    #1;
    check_vec(mk("r_held", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0));
    @(negedge clk);
    nReset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply(mk("r_after", 0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
